// File: rtl/ucsbece154b_selfcheck_pkg.sv
// rtl/ucsbece154b_selfcheck_pkg.sv - shared state encoding and width helpers for the end-of-run checker
package ucsbece154b_selfcheck_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Index width never collapses to zero, even for a single channel.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ucsbece154b_cyc_counter.sv
// rtl/ucsbece154b_cyc_counter.sv - loadable down-counter with a "count <= 1" flag for the RUN phase
module ucsbece154b_cyc_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         le_one
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - W'(1);
    end
  end

  assign le_one = (count <= W'(1));

endmodule

// File: rtl/ucsbece154b_selfcheck.sv
// rtl/ucsbece154b_selfcheck.sv - end-of-run probe/expect checker; UCSBECE154B_SELFCHECK_SNAPSHOT_EN freezes probes for CHECK
module ucsbece154b_selfcheck
  import ucsbece154b_selfcheck_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int WIDTH   = 32,
  parameter int CYCLE_W = 16,
  localparam int IW = idx_width(NUM_CH),
  localparam int CW = count_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CYCLE_W-1:0]      run_cycles,
  input  logic                    halt,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH*WIDTH-1:0] probe_data,
  input  logic [NUM_CH*WIDTH-1:0] expect_data,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [NUM_CH-1:0]       fail_mask,
  output logic [CW-1:0]           fail_count,
  output logic [IW-1:0]           first_fail
);

  state_t                  state;
  state_t                  state_nxt;
  logic [IW-1:0]           idx;
  logic                    le_one;
  logic                    start_ok;
  logic                    go_check;
  logic                    last_ch;
  logic                    mismatch;
  logic [WIDTH-1:0]        sel_probe;
  logic [WIDTH-1:0]        sel_expect;
  logic                    sel_en;
  logic [NUM_CH*WIDTH-1:0] cmp_src;

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign go_check = (state == RUN) && (le_one || halt);
  assign last_ch  = (idx == IW'(NUM_CH - 1));

  ucsbece154b_cyc_counter #(.W(CYCLE_W)) u_run_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (start_ok),
    .load_val (run_cycles),
    .dec      ((state == RUN) && !go_check),
    .le_one   (le_one)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (go_check) state_nxt = CHECK;
      CHECK:   if (last_ch)  state_nxt = DONE;
      DONE:    if (start_ok) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN, CHECK: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

`ifdef UCSBECE154B_SELFCHECK_SNAPSHOT_EN
  logic [NUM_CH*WIDTH-1:0] snap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        snap <= '0;
    else if (go_check) snap <= probe_data;
  end

  assign cmp_src = snap;
`else
  assign cmp_src = probe_data;
`endif

  always_comb begin
    sel_probe  = '0;
    sel_expect = '0;
    sel_en     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == IW'(i)) begin
        sel_probe  = cmp_src[i*WIDTH +: WIDTH];
        sel_expect = expect_data[i*WIDTH +: WIDTH];
        sel_en     = ch_enable[i];
      end
    end
  end

  assign mismatch = sel_en && (sel_probe != sel_expect);

  // fail_count == 0 before the update marks this as the first failure of the run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx        <= '0;
      pass       <= 1'b0;
      fail_mask  <= '0;
      fail_count <= '0;
      first_fail <= '0;
    end else if (start_ok) begin
      idx        <= '0;
      pass       <= 1'b0;
      fail_mask  <= '0;
      fail_count <= '0;
      first_fail <= '0;
    end else if (state == CHECK) begin
      if (mismatch) begin
        fail_mask[idx] <= 1'b1;
        fail_count     <= fail_count + CW'(1);
        if (fail_count == '0) first_fail <= idx;
      end
      if (last_ch) begin
        pass <= (fail_count == '0) && !mismatch;
        idx  <= '0;
      end else begin
        idx  <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154b_selfcheck.sv
// tb/tb_ucsbece154b_selfcheck.sv - directed self-checking bench for ucsbece154b_selfcheck with NUM_CH=4
module tb_ucsbece154b_selfcheck;

  logic         clk;
  logic         reset;
  logic         start;
  logic [15:0]  run_cycles;
  logic         halt;
  logic [3:0]   ch_enable;
  logic [127:0] probe_data;
  logic [127:0] expect_data;
  logic         busy;
  logic         done;
  logic         pass;
  logic [3:0]   fail_mask;
  logic [2:0]   fail_count;
  logic [1:0]   first_fail;

  int checks;
  int failures;
  int n;
  logic idle_ok;

  ucsbece154b_selfcheck #(.NUM_CH(4), .WIDTH(32), .CYCLE_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .run_cycles  (run_cycles),
    .halt        (halt),
    .ch_enable   (ch_enable),
    .probe_data  (probe_data),
    .expect_data (expect_data),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_mask   (fail_mask),
    .fail_count  (fail_count),
    .first_fail  (first_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] rc);
    run_cycles = rc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the number of edges after the start edge until done is seen.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 300);
  endtask

  task automatic set_equal();
    expect_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    probe_data  = expect_data;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    start = 1'b0;
    run_cycles = '0;
    halt = 1'b0;
    ch_enable = 4'hF;
    set_equal();

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_mask", fail_mask, 0);
    check("rst_count", fail_count, 0);
    check("rst_first", first_fail, 0);
    reset = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy || done) idle_ok = 1'b0;
    end
    check("idle_50", idle_ok, 1);

    // All channels equal, 100 run cycles.
    do_start(16'd100);
    check("busy_after_start", busy, 1);
    wait_done(n);
    check("eq_cycles", n, 104);
    check("eq_busy_low", busy, 0);
    check("eq_pass", pass, 1);
    check("eq_mask", fail_mask, 0);
    check("eq_count", fail_count, 0);
    check("eq_first", first_fail, 0);

    // Mismatches on channels 1 and 3.
    probe_data[32 +: 32]  = 32'h0BEEF000;
    expect_data[32 +: 32] = 32'h0BEEF001;
    probe_data[96 +: 32]  = 32'h7;
    expect_data[96 +: 32] = 32'h19;
    do_start(16'd5);
    wait_done(n);
    check("mm_cycles", n, 9);
    check("mm_mask", fail_mask, 4'b1010);
    check("mm_count", fail_count, 2);
    check("mm_first", first_fail, 1);
    check("mm_pass", pass, 0);

    ch_enable = 4'b0101;
    do_start(16'd5);
    wait_done(n);
    check("masked_pass", pass, 1);
    check("masked_mask", fail_mask, 0);
    check("masked_count", fail_count, 0);
    ch_enable = 4'hF;

    // Halt in RUN cycle 10, start while busy ignored.
    set_equal();
    do_start(16'd100);
    repeat (9) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check("halt_busy", busy, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("halt_cycles", n + 12, 14);
    repeat (5) @(negedge clk);
    check("halt_done_hold", done, 1);
    check("halt_pass", pass, 1);

    // Probe 3 changes after the RUN->CHECK edge.
    do_start(16'd2);
    @(negedge clk);
    @(negedge clk);
    probe_data[96 +: 32] = 32'hDEAD0000;
    wait_done(n);
    check("snap_cycles", n + 2, 6);
`ifdef UCSBECE154B_SELFCHECK_SNAPSHOT_EN
    check("snap_pass", pass, 1);
    check("snap_mask", fail_mask, 4'b0000);
`else
    check("live_pass", pass, 0);
    check("live_mask", fail_mask, 4'b1000);
`endif

    // Reset during CHECK cycle 2 with a partial failure on channel 0.
    set_equal();
    probe_data[0 +: 32] = 32'h0;
    do_start(16'd3);
    repeat (4) @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_mask", fail_mask, 4'b0001);
    reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_pass", pass, 0);
    check("arst_mask", fail_mask, 0);
    check("arst_count", fail_count, 0);
    check("arst_first", first_fail, 0);
    @(negedge clk);
    reset = 1'b1;
    set_equal();
    @(negedge clk);
    do_start(16'd0);
    wait_done(n);
    check("fresh_cycles", n, 5);
    check("fresh_pass", pass, 1);
    check("fresh_mask", fail_mask, 0);
    check("fresh_count", fail_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_selfcheck.md
# ucsbece154b_selfcheck

Parametrised, synthesizable end-of-run checker for the pipelined RISC-V core. After a start pulse it lets the core run for a programmed number of cycles, or until halt, then compares NUM_CH probed architectural values (registers, dmem words) against expected constants, one channel per cycle. It reports per-channel failures, failure count, first failing channel and overall pass. It sits beside `ucsbece154b_top`, so the same directed checks run in simulation and on FPGA.

## Interface
- NUM_CH, 8, number of probe/expect channels (≥2)
- WIDTH, 32, bits per channel
- CYCLE_W, 16, width of run-cycle counter
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low forces reset state immediately
- start  in  1  single-cycle request; sampled only in IDLE or DONE
- run_cycles  in  CYCLE_W  cycles to run before checking; sampled with start
- halt  in  1  early end of RUN phase
- ch_enable  in  NUM_CH  per-channel check mask; 1 = checked
- probe_data  in  NUM_CH*WIDTH  observed values, channel i at bits [i*WIDTH +: WIDTH]
- expect_data  in  NUM_CH*WIDTH  expected values, same packing
- busy  out  1  high in RUN and CHECK
- done  out  1  high in DONE
- pass  out  1  valid while done; 1 = no enabled mismatch
- fail_mask  out  NUM_CH  bit i set if channel i mismatched
- fail_count  out  $clog2(NUM_CH+1)  number of mismatches
- first_fail  out  $clog2(NUM_CH)  lowest failing channel index; 0 if none

## Operation
- States: IDLE, RUN, CHECK, DONE.
- IDLE/DONE + start: load cnt = run_cycles; clear fail_mask, fail_count, first_fail, pass; go to RUN.
- RUN: if cnt ≤ 1 or halt, go to CHECK with idx = 0. Otherwise cnt = cnt − 1. run_cycles of 0 or 1 gives one RUN cycle.
- CHECK: each cycle examines channel idx.
  - On mismatch with ch_enable[idx] = 1: set fail_mask[idx] and increment fail_count.
  - If this is the first failure, first_fail = idx.
  - idx = NUM_CH−1 is the last check; then go to DONE and register pass = (no enabled mismatch, including this cycle).
- DONE: outputs hold until start, which starts a new run.
- start while busy is ignored. halt outside RUN is ignored.
- ch_enable is sampled live during CHECK.
- fail_count cannot overflow; its width covers NUM_CH.

## Timing
- Reset values: state IDLE; busy, done, pass = 0; fail_mask, fail_count, first_fail, cnt, idx = 0.
- Start sampled at edge 0:
  - busy is high after edge 0.
  - RUN lasts R = max(run_cycles, 1) cycles, or fewer if halt.
  - CHECK lasts NUM_CH cycles.
  - done, pass and final fail fields are visible after edge R + NUM_CH.
- Halt sampled high in RUN cycle k (first RUN cycle = 1): CHECK starts next cycle. R = k.
- done and busy are never high together.
- Reset low mid-RUN or mid-CHECK: immediate return to reset values. Partial results are discarded.

## Configuration
- UCSBECE154B_SELFCHECK_SNAPSHOT_EN defined:
  - On the RUN→CHECK edge, all probe_data is latched into an internal NUM_CH*WIDTH register.
  - CHECK compares the snapshot. Probe changes during CHECK have no effect.
- Undefined: CHECK compares live probe_data[idx] in each cycle. There is no snapshot register.

## Structure
- Package ucsbece154b_selfcheck_pkg holds:
  - state enum (IDLE, RUN, CHECK, DONE)
  - local function for clog2-based width helpers
- One sub-module, ucsbece154b_cyc_counter: loadable down-counter with a "≤1" flag, used for the RUN phase.
- Channel compare and scan logic stays in the top module.

## Test plan
All scenarios use NUM_CH=4, WIDTH=32.
- Reset held low 3 cycles, then released -> all outputs 0, state IDLE; with no start, stays IDLE for 50 cycles.
- start, run_cycles=100, probes equal expects, ch_enable=4'hF -> busy for 104 cycles; done after edge 104; pass=1, fail_mask=0, fail_count=0.
- Channel 1 probe 32'h0BEEF000 vs expect 32'h0BEEF001, channel 3 probe 32'h7 vs expect 32'h19, ch_enable=4'hF -> fail_mask=4'b1010, fail_count=2, first_fail=1, pass=0.
- Same mismatches, ch_enable=4'b0101 -> pass=1, fail_mask=0.
- run_cycles=100, halt pulsed in RUN cycle 10 -> done after edge 14. start pulsed while busy is ignored, and done stays at edge 14.
- With SNAPSHOT_EN: probe 3 changed to mismatch during CHECK -> pass=1. Without it -> fail_mask[3]=1.
- Reset asserted in CHECK cycle 2 -> immediately all outputs 0; next start behaves as a fresh run.
